// File: rtl/replica_sequencer.sv
// Iteration controller for the replica array: loads one opt per replica, fires run_command,
// replays every stored opt through run_distance and issues the SELF/FOLW metropolis commands.
module replica_sequencer #(
  parameter int unsigned REPLICA_NUM = 32,
  parameter int unsigned OPT_WAIT    = 6,
  parameter int unsigned DIST_WAIT   = 21,
  parameter int unsigned COM_W       = 2,
  parameter int unsigned EXCH_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       iterations,
  input  logic [EXCH_W-1:0] exch_cmd,
  input  logic              gen_valid,
  output logic              gen_ready,
  input  logic [COM_W-1:0]  gen_com,
  input  logic [6:0]        gen_K,
  input  logic [6:0]        gen_L,
  output logic              set_opt,
  output logic              run_command,
  output logic              run_distance,
  output logic [COM_W-1:0]  opt_com,
  output logic [6:0]        K,
  output logic [6:0]        L,
  output logic [EXCH_W-1:0] c_exchange,
  output logic [EXCH_W-1:0] c_metropolis,
  output logic              busy,
  output logic              done,
  output logic [15:0]       iter_cnt
);

  localparam logic [EXCH_W-1:0] XC_NOP  = '0;
  localparam logic [EXCH_W-1:0] XC_SELF = EXCH_W'(1);
  localparam logic [EXCH_W-1:0] XC_FOLW = EXCH_W'(2);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_RUN    = 4'd2;
  localparam logic [3:0] S_OWAIT  = 4'd3;
  localparam logic [3:0] S_DISSUE = 4'd4;
  localparam logic [3:0] S_DWAIT  = 4'd5;
  localparam logic [3:0] S_METRO  = 4'd6;
  localparam logic [3:0] S_EXCH   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam int unsigned SLOT_W   = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1;
  localparam int unsigned WAIT_MAX = (OPT_WAIT > DIST_WAIT) ? OPT_WAIT : DIST_WAIT;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned OPT_W    = COM_W + 14;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(REPLICA_NUM - 1);
  localparam logic [WAIT_W-1:0] OW_LAST   = WAIT_W'(OPT_WAIT - 1);
  localparam logic [WAIT_W-1:0] DW_LAST   = WAIT_W'(DIST_WAIT - 1);

  logic [3:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [15:0]       iter_q, iter_d;
  logic [15:0]       iters_q, iters_d;
  logic [EXCH_W-1:0] exch_q, exch_d;
  logic              store_we;
  logic [OPT_W-1:0]  store_q [REPLICA_NUM];
  logic [OPT_W-1:0]  replay_opt;
  logic              replaying;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wcnt_d   = wcnt_q;
    iter_d   = iter_q;
    iters_d  = iters_q;
    exch_d   = exch_q;
    store_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          iters_d = iterations;
          exch_d  = exch_cmd;
          iter_d  = '0;
          slot_d  = '0;
          state_d = (iterations == 16'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (gen_valid) begin
          store_we = 1'b1;
          if (slot_q == LAST_SLOT) state_d = S_RUN;
          else                     slot_d  = slot_q + SLOT_W'(1);
        end
      end
      S_RUN: begin
        slot_d  = '0;
        wcnt_d  = '0;
        state_d = S_OWAIT;
      end
      S_OWAIT: begin
        if (wcnt_q == OW_LAST) begin
          wcnt_d  = '0;
          state_d = S_DISSUE;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      S_DISSUE: begin
        wcnt_d  = '0;
        state_d = S_DWAIT;
      end
      S_DWAIT: begin
        if (wcnt_q == DW_LAST) begin
          wcnt_d  = '0;
          state_d = S_METRO;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      S_METRO: begin
        if (slot_q == LAST_SLOT) begin
          state_d = S_EXCH;
        end else begin
          slot_d  = slot_q + SLOT_W'(1);
          state_d = S_DISSUE;
        end
      end
      S_EXCH: begin
        // iter_q < iters_q always holds here, so the 16-bit increment cannot wrap
        iter_d  = iter_q + 16'd1;
        slot_d  = '0;
        state_d = ((iter_q + 16'd1) == iters_q) ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      iter_d  = iter_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      wcnt_q  <= '0;
      iter_q  <= '0;
      iters_q <= '0;
      exch_q  <= XC_NOP;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      wcnt_q  <= wcnt_d;
      iter_q  <= iter_d;
      iters_q <= iters_d;
      exch_q  <= exch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store_we) store_q[slot_q] <= {gen_com, gen_K, gen_L};
  end

  assign replay_opt = store_q[slot_q];
  assign replaying  = (state_q == S_DISSUE) || (state_q == S_DWAIT) || (state_q == S_METRO);

  always_comb begin
    gen_ready    = (state_q == S_LOAD);
    set_opt      = gen_ready && gen_valid;
    run_command  = (state_q == S_RUN);
    run_distance = (state_q == S_DISSUE);
    c_exchange   = run_command ? exch_q : XC_NOP;
    c_metropolis = XC_NOP;
    if (state_q == S_METRO) c_metropolis = XC_SELF;
    if (state_q == S_EXCH)  c_metropolis = XC_FOLW;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    iter_cnt = iter_q;
    opt_com  = '0;
    K        = '0;
    L        = '0;
    if (set_opt) begin
      opt_com = gen_com;
      K       = gen_K;
      L       = gen_L;
    end else if (replaying) begin
      {opt_com, K, L} = replay_opt;
    end
  end

endmodule

// File: tb/tb_replica_sequencer.sv
// Scoreboard bench for replica_sequencer: the driver predicts every output event from the
// documented latencies; a negedge monitor pops and compares whatever the DUT presents.
module tb_replica_sequencer;
  localparam int RN = 4;
  localparam int OW = 6;
  localparam int DW = 21;
  localparam logic [1:0] NOP  = 2'd0;
  localparam logic [1:0] SELF = 2'd1;
  localparam logic [1:0] FOLW = 2'd2;
  localparam logic [1:0] OR0 = 2'd1, OR1 = 2'd2, TWO = 2'd3;
  localparam int M_SET = 1, M_RUN = 2, M_DIST = 4, M_SELF = 8, M_FOLW = 16, M_DONE = 32, M_BADM = 64;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, abort = 1'b0, gen_valid = 1'b0;
  logic [15:0] iterations = '0;
  logic [1:0]  exch_cmd = '0, gen_com = '0;
  logic [6:0]  gen_K = '0, gen_L = '0;
  logic gen_ready, set_opt, run_command, run_distance, busy, done;
  logic [1:0]  opt_com, c_exchange, c_metropolis;
  logic [6:0]  K, L;
  logic [15:0] iter_cnt;

  replica_sequencer #(.REPLICA_NUM(RN), .OPT_WAIT(OW), .DIST_WAIT(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .iterations(iterations),
    .exch_cmd(exch_cmd), .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_com(gen_com),
    .gen_K(gen_K), .gen_L(gen_L), .set_opt(set_opt), .run_command(run_command),
    .run_distance(run_distance), .opt_com(opt_com), .K(K), .L(L), .c_exchange(c_exchange),
    .c_metropolis(c_metropolis), .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  typedef struct {
    int          cyc;
    int          mask;
    logic [15:0] opt;
    logic [1:0]  cx;
    logic [15:0] it;
  } ev_t;

  ev_t         q[$];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  bit          mon_en = 1'b0;
  int          hold_end = -1;
  logic [15:0] hold_opt = '0;
  logic [15:0] fixed_opt [RN];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    int          m;
    bit          hit;
    ev_t         e;
    logic [15:0] ob;
    if (mon_en) begin
      ob = {opt_com, K, L};
      m = 0;
      if (set_opt)      m |= M_SET;
      if (run_command)  m |= M_RUN;
      if (run_distance) m |= M_DIST;
      if (c_metropolis == SELF)      m |= M_SELF;
      else if (c_metropolis == FOLW) m |= M_FOLW;
      else if (c_metropolis != NOP)  m |= M_BADM;
      if (done) m |= M_DONE;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("event_time", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      hit = (q.size() > 0 && q[0].cyc == cyc);
      if (hit) begin
        e = q.pop_front();
        chk("event_kind", m, e.mask);
        chk("c_exchange", c_exchange, ((e.mask & M_RUN) != 0) ? e.cx : NOP);
        if ((e.mask & M_DONE) != 0) chk("iter_cnt_done", iter_cnt, e.it);
      end else begin
        chk("no_event", {m, 30'd0} | c_exchange, 0);
      end
      if (hit && (e.mask & (M_SET | M_DIST)) != 0) chk("opt_payload", ob, e.opt);
      else if (cyc <= hold_end)                    chk("opt_hold", ob, hold_opt);
      else                                         chk("opt_idle", ob, 0);
      if (hit && (e.mask & M_DIST) != 0) begin
        hold_opt = e.opt;
        hold_end = cyc + DW + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_gen();
    gen_valid = 1'($urandom_range(0, 1));
    gen_com = 2'($urandom);
    gen_K = 7'($urandom);
    gen_L = 7'($urandom);
  endtask

  task automatic push(input int c, input int m, input logic [15:0] o, input logic [1:0] x,
                      input logic [15:0] it);
    ev_t e;
    e.cyc = c; e.mask = m; e.opt = o; e.cx = x; e.it = it;
    q.push_back(e);
  endtask

  task automatic flush_after(input int x);
    while (q.size() > 0 && q[q.size()-1].cyc > x) void'(q.pop_back());
    if (hold_end > x) hold_end = x;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin rand_gen(); step(); end
  endtask

  task automatic check_quiet(input string tag, input logic [15:0] exp_iter);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pulses"}, {gen_ready, set_opt, run_command, run_distance, done}, 0);
    chk({tag, "_opt"}, {opt_com, K, L}, 0);
    chk({tag, "_cmds"}, {c_exchange, c_metropolis}, 0);
    chk({tag, "_iter"}, iter_cnt, exp_iter);
  endtask

  // One start..done job; abort_rep/reset_acc >= 0 cut the first iteration short.
  task automatic run_job(input int iters, input int vprob, input int abort_rep,
                         input int reset_acc, input bit fixed);
    int s, a, rc, fw, ldstart, acc, x;
    logic [15:0] st [RN];
    logic [1:0] xc;
    s = cyc;
    xc = 2'($urandom);
    start = 1'b1; iterations = 16'(iters); exch_cmd = xc; abort = 1'b0;
    rand_gen();
    step();
    start = 1'b0;
    if (iters == 0) begin
      push(s + 1, M_DONE, 0, NOP, 0);
      idle(3);
      return;
    end
    ldstart = s + 1;
    for (int it = 0; it < iters; it++) begin
      while (cyc < ldstart) begin rand_gen(); start = 1'($urandom_range(0, 1)); step(); end
      acc = 0;
      a = cyc;
      while (acc < RN) begin
        start = 1'($urandom_range(0, 1));
        rand_gen();
        if (fixed) {gen_com, gen_K, gen_L} = fixed_opt[acc];
        gen_valid = ($urandom_range(1, 100) <= vprob);
        if (it == 0 && acc == reset_acc && !gen_valid) begin
          start = 1'b0; reset = 1'b0; x = cyc;
          flush_after(x);
          step();
          reset = 1'b1;
          check_quiet("midload_reset", 16'd0);
          idle(3);
          return;
        end
        if (gen_valid) begin
          st[acc] = {gen_com, gen_K, gen_L};
          push(cyc, M_SET, st[acc], NOP, 0);
          acc++;
        end
        a = cyc;
        step();
      end
      rc = a + 1;
      push(rc, M_RUN, 0, xc, 0);
      for (int i = 0; i < RN; i++) begin
        push(rc + OW + 1 + i * (DW + 2), M_DIST, st[i], NOP, 0);
        push(rc + OW + 1 + i * (DW + 2) + DW + 1, M_SELF, 0, NOP, 0);
      end
      fw = rc + OW + 1 + RN * (DW + 2);
      push(fw, M_FOLW, 0, NOP, 0);
      if (it == iters - 1) push(fw + 1, M_DONE, 0, NOP, 16'(iters));
      ldstart = fw + 1;
      if (it == 0 && abort_rep >= 0) begin
        x = rc + OW + 1 + abort_rep * (DW + 2) + 5;
        while (cyc < x) begin rand_gen(); start = 1'($urandom_range(0, 1)); step(); end
        start = 1'b0; abort = 1'b1;
        flush_after(x);
        step();
        abort = 1'b0;
        check_quiet("abort", 16'd0);
        idle(3);
        return;
      end
    end
    while (cyc <= fw + 1) begin rand_gen(); start = 1'($urandom_range(0, 1)); step(); end
    idle(2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    fixed_opt[0] = {TWO, 7'd5, 7'd9};
    fixed_opt[1] = {OR0, 7'd1, 7'd2};
    fixed_opt[2] = {OR1, 7'd7, 7'd3};
    fixed_opt[3] = {TWO, 7'd0, 7'd127};
    reset = 1'b0;
    repeat (3) begin rand_gen(); step(); end
    check_quiet("reset", 16'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    idle(2);
    run_job(1, 100, -1, -1, 1'b0);
    run_job(1, 100, -1, -1, 1'b1);
    run_job(1, 45, -1, -1, 1'b1);
    run_job(0, 100, -1, -1, 1'b0);
    run_job(3, 70, -1, -1, 1'b0);
    // start and abort together in IDLE must leave the sequencer idle with iter_cnt intact
    start = 1'b1; abort = 1'b1; iterations = 16'd1;
    step();
    start = 1'b0; abort = 1'b0;
    check_quiet("abort_start", 16'd3);
    idle(2);
    run_job(2, 80, 2, -1, 1'b0);
    run_job(1, 100, -1, -1, 1'b0);
    run_job(1, 100, -1, 2, 1'b0);
    run_job(1, 60, -1, -1, 1'b0);
    for (int j = 0; j < 3; j++) run_job($urandom_range(1, 2), $urandom_range(40, 100), -1, -1, 1'b0);
    for (int w = 0; w < 200 && q.size() > 0; w++) step();
    chk("queue_drain", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
